// File: rtl/sysu_7seg_scan_driver.sv
// ============================================================================
// sysu_7seg_scan_driver: time-multiplexed BCD seven-segment display driver.
// Provides lamp test, blanking and leading-zero ripple blanking.
// Optional feature macro: SYSU_SEG_HEX_EN (A-F glyphs for codes 10-15).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysu_7seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit KEEP_LSD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  LT_n,
  input  logic                  BI_n,
  input  logic                  RBI_n,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start,
  output logic                  RBO_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
`ifdef SYSU_SEG_HEX_EN
      4'd10:   s = 7'b1110111;
      4'd11:   s = 7'b0011111;
      4'd12:   s = 7'b1001110;
      4'd13:   s = 7'b0111101;
      4'd14:   s = 7'b1001111;
      default: s = 7'b1000111;
`else
      4'd10:   s = 7'b0001101;
      4'd11:   s = 7'b0011001;
      4'd12:   s = 7'b0100011;
      4'd13:   s = 7'b1001011;
      4'd14:   s = 7'b0001111;
      default: s = 7'b0000000;
`endif
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fs_q, fs_d;
  logic                rbo_q, rbo_d;

  logic [DIGITS-1:0]   w_zero;
  logic [DIGITS-1:0]   w_blank_chain;
  logic [DIGITS-1:0]   w_blank;
  logic                w_pre_last;
  logic [3:0]          w_cur_digit;
  logic                w_cur_blank;

  // Ripple-blank chain runs from the most significant digit downward.
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    assign w_zero[i] = (disp_q[4*i +: 4] == 4'd0);
    if (i == DIGITS - 1) begin : g_msd
      assign w_blank_chain[i] = w_zero[i] & ~RBI_n;
    end else begin : g_lower
      assign w_blank_chain[i] = w_zero[i] & w_blank_chain[i+1];
    end
    if (i == 0) begin : g_lsd
      assign w_blank[i] = KEEP_LSD ? 1'b0 : w_blank_chain[i];
    end else begin : g_upper
      assign w_blank[i] = w_blank_chain[i];
    end
  end

  assign w_pre_last = (pre_q == PW'(SCAN_DIV - 1));

  always_comb begin
    disp_d      = load ? bcd_in : disp_q;
    pre_d       = w_pre_last ? '0 : pre_q + 1'b1;
    idx_d       = idx_q;
    if (w_pre_last) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    w_cur_digit = 4'd0;
    w_cur_blank = 1'b0;
    an_d        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_cur_digit = disp_q[4*i +: 4];
        w_cur_blank = w_blank[i];
        an_d[i]     = 1'b1;
      end
    end

    if (!BI_n) begin
      seg_d = 7'b0000000;
    end else if (!LT_n) begin
      seg_d = 7'b1111111;
    end else if (w_cur_blank) begin
      seg_d = 7'b0000000;
    end else begin
      seg_d = decode(w_cur_digit);
    end

    fs_d  = (idx_q == '0) && (pre_q == '0);
    rbo_d = ~((&w_zero) & ~RBI_n & LT_n & BI_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 7'b0000000;
      an_q   <= '0;
      fs_q   <= 1'b0;
      rbo_q  <= 1'b1;
    end else begin
      disp_q <= disp_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fs_q   <= fs_d;
      rbo_q  <= rbo_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign RBO_n       = rbo_q;

endmodule

`default_nettype wire

// File: tb/tb_sysu_7seg_scan_driver.sv
// ============================================================================
// tb_sysu_7seg_scan_driver: randomized self-checking bench with a cycle-count
// reference model; two instances cover KEEP_LSD=1/SCAN_DIV=3 and 0/5.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sysu_7seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        LT_n, BI_n, RBI_n;

  logic [6:0]  seg1, seg2;
  logic [3:0]  an1, an2;
  logic        fs1, fs2, rbo1, rbo2;

  int total_cnt  = 0;
  int passed_cnt = 0;

  // Model state: edges since reset release and the model display register.
  int          n;
  logic [15:0] disp_m;
  logic [6:0]  e1_seg, e2_seg;
  logic [3:0]  e1_an, e2_an;
  logic        e1_fs, e2_fs, e1_rbo, e2_rbo;

  always #5 clk = ~clk;

  sysu_7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(3), .KEEP_LSD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .LT_n(LT_n), .BI_n(BI_n), .RBI_n(RBI_n),
    .seg(seg1), .an(an1), .frame_start(fs1), .RBO_n(rbo1)
  );

  sysu_7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(5), .KEEP_LSD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .LT_n(LT_n), .BI_n(BI_n), .RBI_n(RBI_n),
    .seg(seg2), .an(an2), .frame_start(fs2), .RBO_n(rbo2)
  );

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
`ifdef SYSU_SEG_HEX_EN
      10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101;
      14: return 7'b1001111; default: return 7'b1000111;
`else
      10: return 7'b0001101; 11: return 7'b0011001;
      12: return 7'b0100011; 13: return 7'b1001011;
      14: return 7'b0001111; default: return 7'b0000000;
`endif
    endcase
  endfunction

  // A digit is ripple-blanked when it and every more significant digit is zero.
  function automatic logic [6:0] m_seg(input logic [15:0] d, input int idx,
                                       input logic lt, input logic bi,
                                       input logic rbi, input bit keep);
    int upper;
    bit blank;
    upper = int'(d >> (4 * idx));
    blank = (upper == 0) && !rbi && !(keep && idx == 0);
    if (!bi)       return 7'b0000000;
    if (!lt)       return 7'b1111111;
    if (blank)     return 7'b0000000;
    return glyph(upper & 15);
  endfunction

  task automatic tick();
    int i1, i2;
    @(posedge clk);
    #1;
    if (rst) begin
      n = 0; disp_m = '0;
      e1_seg = '0; e1_an = '0; e1_fs = 1'b0; e1_rbo = 1'b1;
      e2_seg = '0; e2_an = '0; e2_fs = 1'b0; e2_rbo = 1'b1;
    end else begin
      n++;
      i1 = ((n - 1) / 3) % 4;
      i2 = ((n - 1) / 5) % 4;
      e1_seg = m_seg(disp_m, i1, LT_n, BI_n, RBI_n, 1'b1);
      e2_seg = m_seg(disp_m, i2, LT_n, BI_n, RBI_n, 1'b0);
      e1_an  = 4'(1 << i1);
      e2_an  = 4'(1 << i2);
      e1_fs  = ((n - 1) % 12) == 0;
      e2_fs  = ((n - 1) % 20) == 0;
      e1_rbo = !(disp_m == 16'h0 && !RBI_n && LT_n && BI_n);
      e2_rbo = e1_rbo;
      if (load) disp_m = bcd_in;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; bcd_in = '0; LT_n = 1'b1; BI_n = 1'b1; RBI_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if ({seg1, an1, fs1, rbo1, seg2, an2, fs2, rbo2} !== {7'd0, 4'd0, 1'b0, 1'b1, 7'd0, 4'd0, 1'b0, 1'b1}) begin
        $display("FAIL reset: got seg1=%b an1=%b fs1=%b rbo1=%b seg2=%b an2=%b fs2=%b rbo2=%b, need 0/0/0/1",
                 seg1, an1, fs1, rbo1, seg2, an2, fs2, rbo2);
      end else passed_cnt++;
    end
  endtask

  task automatic test_scan();
    rst = 1'b0;
    for (int c = 0; c < 26; c++) begin
      tick();
      total_cnt++;
      if ({seg1, an1, fs1, rbo1} !== {e1_seg, e1_an, e1_fs, e1_rbo}) begin
        $display("FAIL scan dut1 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 n, seg1, an1, fs1, rbo1, e1_seg, e1_an, e1_fs, e1_rbo);
      end else passed_cnt++;
      total_cnt++;
      if ({seg2, an2, fs2, rbo2} !== {e2_seg, e2_an, e2_fs, e2_rbo}) begin
        $display("FAIL scan dut2 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 n, seg2, an2, fs2, rbo2, e2_seg, e2_an, e2_fs, e2_rbo);
      end else passed_cnt++;
    end
  endtask

  task automatic test_pattern(input logic [15:0] word, input logic rbi,
                              input logic lt, input logic bi, input int cycles);
    load = 1'b1; bcd_in = word; RBI_n = rbi; LT_n = lt; BI_n = bi;
    tick();
    load = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      total_cnt++;
      if ({seg1, an1, fs1, rbo1} !== {e1_seg, e1_an, e1_fs, e1_rbo}) begin
        $display("FAIL pattern %h dut1 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 word, n, seg1, an1, fs1, rbo1, e1_seg, e1_an, e1_fs, e1_rbo);
      end else passed_cnt++;
      total_cnt++;
      if ({seg2, an2, fs2, rbo2} !== {e2_seg, e2_an, e2_fs, e2_rbo}) begin
        $display("FAIL pattern %h dut2 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 word, n, seg2, an2, fs2, rbo2, e2_seg, e2_an, e2_fs, e2_rbo);
      end else passed_cnt++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      load = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < 4; d++) begin
        bcd_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      RBI_n = 1'($urandom_range(0, 1));
      LT_n  = ($urandom_range(0, 7) != 0);
      BI_n  = ($urandom_range(0, 7) != 0);
      tick();
      total_cnt++;
      if ({seg1, an1, fs1, rbo1} !== {e1_seg, e1_an, e1_fs, e1_rbo}) begin
        $display("FAIL random dut1 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 n, seg1, an1, fs1, rbo1, e1_seg, e1_an, e1_fs, e1_rbo);
      end else passed_cnt++;
      total_cnt++;
      if ({seg2, an2, fs2, rbo2} !== {e2_seg, e2_an, e2_fs, e2_rbo}) begin
        $display("FAIL random dut2 n=%0d: got seg=%b an=%b fs=%b rbo=%b, need seg=%b an=%b fs=%b rbo=%b",
                 n, seg2, an2, fs2, rbo2, e2_seg, e2_an, e2_fs, e2_rbo);
      end else passed_cnt++;
    end
    load = 1'b0; LT_n = 1'b1; BI_n = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int budget;
    budget = 0;
    while ((((n - 1) / 5) % 4) != 2 && budget < 40) begin
      tick();
      budget++;
    end
    total_cnt++;
    if (an2 !== 4'b0100) begin
      $display("FAIL mid_reset_setup: got an2=%b, need 0100 within 40 cycles", an2);
    end else passed_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({seg2, an2, fs2, rbo2, an1} !== {7'd0, 4'd0, 1'b0, 1'b1, 4'd0}) begin
      $display("FAIL mid_reset: got seg2=%b an2=%b fs2=%b rbo2=%b an1=%b, need 0/0/0/1/0",
               seg2, an2, fs2, rbo2, an1);
    end else passed_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({an2, fs2, an1, fs1} !== {4'b0001, 1'b1, 4'b0001, 1'b1}) begin
      $display("FAIL mid_reset_restart: got an2=%b fs2=%b an1=%b fs1=%b, need 0001/1/0001/1",
               an2, fs2, an1, fs1);
    end else passed_cnt++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pattern(16'h0305, 1'b0, 1'b1, 1'b1, 24);
    test_pattern(16'h0000, 1'b0, 1'b1, 1'b1, 24);
    test_pattern(16'h0000, 1'b1, 1'b1, 1'b1, 12);
    test_pattern(16'h9070, 1'b0, 1'b0, 1'b1, 12);
    test_pattern(16'h9070, 1'b0, 1'b0, 1'b0, 12);
    test_pattern(16'hFEDC, 1'b1, 1'b1, 1'b1, 24);
    test_pattern(16'h0AB0, 1'b0, 1'b1, 1'b1, 24);
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
